// File: rtl/mtimer_unit.sv
// rtl/mtimer_unit.sv - machine timer: 64-bit mtime/mtimecmp behind a 32-bit register port
// Optional build macro TIMER_PRESCALER_EN: mtime advances once every PRESCALE enabled cycles.
module mtimer_unit #(
  parameter int ADDR_W   = 5,
  parameter int PRESCALE = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              timer_int
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q;
  logic        timer_int_q;

  // Word-aligned offset: the low two address bits never select anything.
  logic [ADDR_W-1:0] off;
  assign off = addr & ~ADDR_W'(3);

  logic hit_mlo, hit_mhi, hit_clo, hit_chi, hit_ctrl;
  assign hit_mlo  = (off == ADDR_W'(8'h00));
  assign hit_mhi  = (off == ADDR_W'(8'h04));
  assign hit_clo  = (off == ADDR_W'(8'h08));
  assign hit_chi  = (off == ADDR_W'(8'h0C));
  assign hit_ctrl = (off == ADDR_W'(8'h10));

  logic wr, rd;
  assign wr = sel & wr_en;
  assign rd = sel & rd_en;

  logic tick;

`ifdef TIMER_PRESCALER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;

  assign tick = en_q && (pre_q == PW'(PRESCALE - 1));

  // Prescale counter: restarts on any mtime write, wraps after the tick cycle, holds while disabled.
  always_comb begin
    pre_d = pre_q;
    if (wr && (hit_mlo || hit_mhi)) begin
      pre_d = '0;
    end else if (en_q) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= pre_d;
  end
`else
  assign tick = en_q;
`endif

  // Next-state for counter, compare, control and read path; a write to one mtime half suppresses the increment.
  always_comb begin
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    en_d        = en_q;
    hi_shadow_d = hi_shadow_q;
    rdata_d     = rdata_q;

    if (wr) begin
      if (hit_mlo)  mtime_d            = {mtime_q[63:32], wdata};
      if (hit_mhi)  mtime_d            = {wdata, mtime_q[31:0]};
      if (hit_clo)  mtimecmp_d[31:0]   = wdata;
      if (hit_chi)  mtimecmp_d[63:32]  = wdata;
      if (hit_ctrl) en_d               = wdata[0];
    end

    if (rd) begin
      if (hit_mlo) begin
        rdata_d     = mtime_q[31:0];
        hi_shadow_d = mtime_q[63:32];
      end else if (hit_mhi) begin
        rdata_d = hi_shadow_q;
      end else if (hit_clo) begin
        rdata_d = mtimecmp_q[31:0];
      end else if (hit_chi) begin
        rdata_d = mtimecmp_q[63:32];
      end else if (hit_ctrl) begin
        rdata_d = {31'd0, en_q};
      end else begin
        rdata_d = 32'd0;
      end
    end
  end

  // State registers; interrupt compares the post-update values so it tracks mtime/mtimecmp without lag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mtime_q       <= 64'd0;
      mtimecmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q          <= 1'b1;
      hi_shadow_q   <= 32'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      timer_int_q   <= 1'b0;
    end else begin
      mtime_q       <= mtime_d;
      mtimecmp_q    <= mtimecmp_d;
      en_q          <= en_d;
      hi_shadow_q   <= hi_shadow_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rd;
      timer_int_q   <= (mtime_d >= mtimecmp_d);
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign timer_int   = timer_int_q;

endmodule

// File: tb/tb_mtimer_unit.sv
// tb/tb_mtimer_unit.sv - directed self-checking bench for mtimer_unit (default build)
module tb_mtimer_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic [4:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        timer_int;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] A_MLO = 5'h00, A_MHI = 5'h04, A_CLO = 5'h08,
                         A_CHI = 5'h0C, A_CTRL = 5'h10, A_BAD = 5'h14;

  mtimer_unit #(.ADDR_W(5), .PRESCALE(10)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    sel = 1'b1; rd_en = 1'b1; addr = a;
    @(posedge clk); #1;
    sel = 1'b0; rd_en = 1'b0;
    check({tag, "_valid"}, {63'd0, rdata_valid}, 64'd1);
    check(tag, {32'd0, rdata}, {32'd0, exp});
  endtask

  initial begin
    // Reset state
    cycles(2);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_valid", {63'd0, rdata_valid}, 64'd0);
    check("rst_int", {63'd0, timer_int}, 64'd0);
    rst = 1'b1;

    // Free-running count from reset: 5 idle edges then read at the 6th
    cycles(5);
    do_read("idle_lo", A_MLO, 32'd5);
    check("idle_int", {63'd0, timer_int}, 64'd0);
    cycles(1);                                    // mtime = 7
    check("valid_pulse", {63'd0, rdata_valid}, 64'd0);

    // Compare match at 20
    do_write(A_CHI, 32'd0);                       // mtime = 8
    do_write(A_CLO, 32'd20);                      // mtime = 9
    check("cmp_pre", {63'd0, timer_int}, 64'd0);
    cycles(10);                                   // mtime = 19
    check("cmp_19", {63'd0, timer_int}, 64'd0);
    cycles(1);                                    // mtime = 20
    check("cmp_20", {63'd0, timer_int}, 64'd1);
    cycles(3);                                    // mtime = 23
    check("cmp_hold", {63'd0, timer_int}, 64'd1);
    do_write(A_CLO, 32'hFFFF_FFFF);               // mtime = 24
    check("cmp_clear", {63'd0, timer_int}, 64'd0);

    // Carry from LO to HI with tear-free shadow read
    do_write(A_MHI, 32'd0);
    do_write(A_MLO, 32'hFFFF_FFFE);
    cycles(2);                                    // mtime = 1_0000_0000
    do_read("carry_lo", A_MLO, 32'd0);
    do_read("carry_hi", A_MHI, 32'd1);            // mtime = 1_0000_0002 after

    // 64-bit wrap
    do_write(A_CHI, 32'hFFFF_FFFF);               // cmp all ones, mtime = 1_0000_0003
    do_write(A_MHI, 32'hFFFF_FFFF);
    check("wrap_pre_int", {63'd0, timer_int}, 64'd0);
    do_write(A_MLO, 32'hFFFF_FFFF);
    check("wrap_max_int", {63'd0, timer_int}, 64'd1);
    cycles(1);                                    // mtime = 0
    check("wrap_int", {63'd0, timer_int}, 64'd0);
    do_read("wrap_lo", A_MLO, 32'd0);
    do_read("wrap_hi", A_MHI, 32'd0);             // mtime = 2 after

    // Disable / freeze / resume
    do_write(A_CTRL, 32'hFFFF_FFFE);              // last tick -> mtime = 3, EN = 0
    do_read("ctrl_off", A_CTRL, 32'd0);
    cycles(50);
    do_read("frozen_lo", A_MLO, 32'd3);
    do_read("bad_off", A_BAD, 32'd0);
    do_write(A_BAD, 32'hDEAD_BEEF);
    do_read("frozen_hi", A_MHI, 32'd0);
    do_write(A_CTRL, 32'd1);                      // no tick this edge, mtime = 3
    do_read("ctrl_on", A_CTRL, 32'd1);            // mtime = 4 after
    do_read("resume_lo", A_MLO, 32'd4);           // mtime = 5 after

    // Simultaneous read and write returns the old value
    sel = 1'b1; rd_en = 1'b1; wr_en = 1'b1; addr = A_CLO; wdata = 32'd5;
    @(posedge clk); #1;                           // mtime = 6
    sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    check("rw_old", {32'd0, rdata}, 64'h0000_0000_FFFF_FFFF);
    do_read("rw_new", A_CLO, 32'd5);              // mtime = 7

    // sel = 0 ignores strobes
    sel = 1'b0; wr_en = 1'b1; rd_en = 1'b1; addr = A_CTRL; wdata = 32'd0;
    @(posedge clk); #1;                           // mtime = 8
    wr_en = 1'b0; rd_en = 1'b0;
    check("nosel_valid", {63'd0, rdata_valid}, 64'd0);
    do_read("nosel_lo", A_MLO, 32'd8);

    // Reset during a read drops it
    rst = 1'b0; sel = 1'b1; rd_en = 1'b1; addr = A_CLO;
    @(posedge clk); #1;
    sel = 1'b0; rd_en = 1'b0;
    check("rst_rd_valid", {63'd0, rdata_valid}, 64'd0);
    check("rst_rd_data", {32'd0, rdata}, 64'd0);
    rst = 1'b1;
    cycles(1);
    check("rst_rd_after", {63'd0, rdata_valid}, 64'd0);
    do_read("rst_cmp_hi", A_CHI, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mtimer_unit.md
Name: mtimer_unit

Overview:
- Machine-timer peripheral sitting directly upstream of the pipeline core.
- Drives the core's timer_int input.
- Holds the 64-bit mtime counter and mtimecmp compare register, both memory-mapped on the data-memory side through a simple 32-bit register port.
- timer_int is raised when mtime >= mtimecmp. Software clears it by rewriting mtimecmp.

Parameters:
- ADDR_W, 5, width of the register offset address.
- PRESCALE, 10, clock cycles per mtime tick. Used only when TIMER_PRESCALER_EN is defined; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- sel  input  1  block select from the LSU address decode.
- addr  input  ADDR_W  byte offset; word-aligned (addr[1:0] ignored).
- wr_en  input  1  write strobe; valid only with sel=1.
- rd_en  input  1  read strobe; valid only with sel=1.
- wdata  input  32  write data.
- rdata  output  32  registered read data.
- rdata_valid  output  1  high for exactly one cycle, the cycle after an accepted read.
- timer_int  output  1  machine timer interrupt to the core, level, registered.

Behaviour:
- Register map (offsets):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 = EN; other bits read 0 and ignore writes.
  - Any other offset reads 0; writes to it are ignored.
- Reset (rst=0 at a clk edge), all values registered:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, EN=1.
  - hi_shadow=0, rdata=0, rdata_valid=0, timer_int=0.
  - Prescale counter=0.
  - Reset mid-transaction drops the pending read; no rdata_valid is issued.
- Counting:
  - When EN=1 and a tick occurs, mtime <= mtime+1, a full 64-bit increment with carry from LO into HI.
  - Wrap: 64'hFFFF_FFFF_FFFF_FFFF -> 0.
  - When EN=0, mtime holds its value.
- Writes (sel & wr_en), take effect at the clock edge:
  - A write to MTIME_LO or MTIME_HI replaces that half. It overrides the increment in that cycle; the other half keeps its pre-increment value (no carry applied).
  - A write to MTIMECMP_LO or MTIMECMP_HI replaces that half.
- Reads (sel & rd_en):
  - rdata is loaded at the edge with the pre-edge register value; rdata_valid=1 in the next cycle.
  - Read-after-write to the same address in the same cycle returns the old value.
  - Reading MTIME_LO also copies mtime[63:32] into hi_shadow at the same edge.
  - Reading MTIME_HI returns hi_shadow, not live mtime[63:32]. This gives a tear-free 64-bit read when software reads LO then HI.
- sel=1 with both wr_en and rd_en high: both the write and the read are performed; the read returns the old value.
- sel=0: wr_en and rd_en are ignored.
- Interrupt:
  - timer_int <= (mtime >= mtimecmp), an unsigned 64-bit compare on the post-update (next-state) values.
  - So timer_int rises in the same cycle that mtime first reaches mtimecmp, and falls the cycle after a mtimecmp write raises it above mtime.
  - The compare remains active when EN=0.
- No backpressure: every accepted access completes; one read outstanding at most.

Optional Feature:
- Macro TIMER_PRESCALER_EN.
- Defined:
  - A prescale counter counts 0..PRESCALE-1 while EN=1. A tick occurs on the cycle it equals PRESCALE-1, and it then wraps to 0.
  - The counter clears to 0 on any MTIME_LO/HI write.
  - The counter holds while EN=0.
- Undefined: every cycle with EN=1 is a tick; no prescale counter logic is generated.

Test Plan:
- Reset then idle, no macro: after 5 cycles, read MTIME_LO -> rdata_valid one cycle later; rdata = 5 plus cycles elapsed to the read edge; timer_int=0.
- Write MTIMECMP_HI=0, then MTIMECMP_LO=20 -> timer_int rises the cycle mtime reaches 20 and stays high; then write MTIMECMP_LO=0xFFFF_FFFF -> timer_int falls the next cycle.
- Write MTIME_HI=0, MTIME_LO=0xFFFF_FFFE; wait 2 ticks -> read LO gives 0, read HI gives 1 (carry taken, shadow consistent).
- Write MTIME_HI=0xFFFF_FFFF, MTIME_LO=0xFFFF_FFFF, MTIMECMP=all-ones -> timer_int=1; one tick later mtime=0 and timer_int=0 (wrap).
- Write CTRL=0 -> mtime frozen across 50 cycles; read offset 0x14 -> 0; write CTRL=1 -> counting resumes from the frozen value.
- With TIMER_PRESCALER_EN, PRESCALE=4: 40 cycles after reset, mtime=10. A write MTIME_LO=0 at cycle 41 -> next increment occurs 4 cycles later.
